io_reg_cell: RTL and testbench

- Sequential core of the AP3 IO register tile.
- Sits directly downstream of the io_reg routing muxes. Those muxes select its data, output-enable and clock-enable sources; this block supplies the registered pad-side signals.
- Provides:
  - registered output data (OQ);
  - registered output enable (OE);
  - a synchronized, optionally glitch-filtered input capture (IQ);
  - single-cycle rise/fall strobes on IQ.

---
 rtl/io_reg_cell.sv | 142 ++++++++++++++
 tb/tb_io_reg_cell.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/io_reg_cell.sv
// io_reg_cell: sequential core of the AP3 IO register tile (registered OQ/OE, synchronized IQ with edge strobes).
// Define IO_REG_CELL_FILTER_EN to build the glitch filter between the synchronizer and IQ.
module io_reg_cell #(
  parameter logic        INIT_OQ        = 1'b0,
  parameter logic        INIT_OE        = 1'b0,
  parameter int unsigned IN_SYNC_STAGES = 2,
  parameter int unsigned FILTER_CYCLES  = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE,
  input  logic OD,
  input  logic OEN_D,
  input  logic PAD_I,
  output logic OQ,
  output logic OE,
  output logic IQ,
  output logic IQ_RISE,
  output logic IQ_FALL
);

  // Reject out-of-range configurations at elaboration.
  generate
    if (IN_SYNC_STAGES < 1 || IN_SYNC_STAGES > 3) begin : g_bad_sync
      $error("io_reg_cell: IN_SYNC_STAGES must be 1..3");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter
      $error("io_reg_cell: FILTER_CYCLES must be 1..15");
    end
  endgenerate

  logic [IN_SYNC_STAGES-1:0] sync_q;
  logic                      s;
  logic                      iq_d;

  // Pad synchronizer: free-running, only reset clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= PAD_I;
      for (int i = 1; i < IN_SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[IN_SYNC_STAGES-1];

  // Output data and output enable registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OQ <= INIT_OQ;
      OE <= INIT_OE;
    end else if (CE) begin
      OQ <= OD;
      OE <= OEN_D;
    end
  end

`ifdef IO_REG_CELL_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } flt_state_e;

  flt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // S must differ from IQ for FILTER_CYCLES enabled cycles before IQ follows.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iq_d    = IQ;
    if (CE) begin
      case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (s != IQ) begin
            if (FILTER_CYCLES == 1) begin
              iq_d = s;
            end else begin
              state_d = ST_QUALIFY;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_QUALIFY: begin
          if (s == IQ) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q >= CNT_LAST) begin
            iq_d    = s;
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    iq_d = IQ;
    if (CE) begin
      iq_d = s;
    end
  end
`endif

  // IQ and its edge strobes; a reset-forced change never strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      IQ      <= 1'b0;
      IQ_RISE <= 1'b0;
      IQ_FALL <= 1'b0;
    end else begin
      IQ      <= iq_d;
      IQ_RISE <= iq_d & ~IQ;
      IQ_FALL <= ~iq_d & IQ;
    end
  end

endmodule

// File: tb/tb_io_reg_cell.sv
// Directed self-checking bench for io_reg_cell (INIT_OQ=1, INIT_OE=0, 2 sync stages, 4 filter cycles).
module tb_io_reg_cell;

  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 4;
`ifdef IO_REG_CELL_FILTER_EN
  localparam int unsigned FILT_LAT = FILT;
`else
  localparam int unsigned FILT_LAT = 1;
`endif
  localparam int unsigned PAD_LAT = SYNC + FILT_LAT;

  logic CLK = 1'b0;
  logic RST, CE, OD, OEN_D, PAD_I;
  logic OQ, OE, IQ, IQ_RISE, IQ_FALL;

  int n_checks = 0;
  int n_fails  = 0;

  io_reg_cell #(
    .INIT_OQ       (1'b1),
    .INIT_OE       (1'b0),
    .IN_SYNC_STAGES(SYNC),
    .FILTER_CYCLES (FILT)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .CE     (CE),
    .OD     (OD),
    .OEN_D  (OEN_D),
    .PAD_I  (PAD_I),
    .OQ     (OQ),
    .OE     (OE),
    .IQ     (IQ),
    .IQ_RISE(IQ_RISE),
    .IQ_FALL(IQ_FALL)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_in(input string tag, input logic iq_e, input logic rise_e, input logic fall_e);
    chk({tag, ".iq"}, IQ, iq_e);
    chk({tag, ".rise"}, IQ_RISE, rise_e);
    chk({tag, ".fall"}, IQ_FALL, fall_e);
  endtask

  // Drive PAD_I to lvl and expect IQ to follow exactly lat edges later with one strobe.
  task automatic pad_edge(input string tag, input logic lvl, input int unsigned lat);
    PAD_I = lvl;
    for (int k = 1; k <= int'(lat); k++) begin
      step();
      if (k < int'(lat)) chk_in(tag, ~lvl, 1'b0, 1'b0);
      else               chk_in(tag, lvl, lvl, ~lvl);
    end
    step();
    chk_in({tag, "_after"}, lvl, 1'b0, 1'b0);
  endtask

  initial begin
    RST = 1'b1; CE = 1'b1; OD = 1'b0; OEN_D = 1'b1; PAD_I = 1'b0;

    // Reset values dominate data inputs and CE.
    step(); step();
    chk("rst.oq", OQ, 1'b1);
    chk("rst.oe", OE, 1'b0);
    chk_in("rst", 1'b0, 1'b0, 1'b0);

    RST = 1'b0; OD = 1'b0;
    step();
    chk("rel.oq", OQ, 1'b0);
    chk("rel.oe", OE, 1'b1);

    // Output path with CE held then gated.
    OD = 1'b1; step(); chk("od1.oq", OQ, 1'b1);
    OD = 1'b0; step(); chk("od0.oq", OQ, 1'b0);
    OD = 1'b1; step(); chk("od1b.oq", OQ, 1'b1);
    CE = 1'b0; OD = 1'b0; OEN_D = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ce0.oq", OQ, 1'b1);
      chk("ce0.oe", OE, 1'b1);
    end
    CE = 1'b1; step();
    chk("ce1.oq", OQ, 1'b0);
    chk("ce1.oe", OE, 1'b0);

    // Pad rise and fall latency with strobes.
    pad_edge("rise", 1'b1, PAD_LAT);
    pad_edge("fall", 1'b0, PAD_LAT);

    // CE low: IQ holds and strobes stay low while the pad moves.
    PAD_I = 1'b1; CE = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_in("iqce0", 1'b0, 1'b0, 1'b0);
    end
    CE = 1'b1;
    for (int k = 1; k <= int'(FILT_LAT); k++) begin
      step();
      if (k < int'(FILT_LAT)) chk_in("iqce1", 1'b0, 1'b0, 1'b0);
      else                    chk_in("iqce1", 1'b1, 1'b1, 1'b0);
    end
    step(); chk_in("iqce1_after", 1'b1, 1'b0, 1'b0);

    // Reset forcing IQ 1->0 gives no fall strobe; pad edge during reset is dropped.
    PAD_I = 1'b0; RST = 1'b1;
    step(); chk_in("rstfall", 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(); chk_in("rstfall_hold", 1'b0, 1'b0, 1'b0);
    end
    PAD_I = 1'b1; RST = 1'b1;
    step(); chk_in("rstedge", 1'b0, 1'b0, 1'b0);
    PAD_I = 1'b0; RST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(); chk_in("rstedge_drop", 1'b0, 1'b0, 1'b0);
    end

`ifdef IO_REG_CELL_FILTER_EN
    // Three-cycle glitch is rejected.
    PAD_I = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_in("glitch_hi", 1'b0, 1'b0, 1'b0);
    end
    PAD_I = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(); chk_in("glitch_lo", 1'b0, 1'b0, 1'b0);
    end
    pad_edge("frise", 1'b1, PAD_LAT);
    pad_edge("ffall", 1'b0, PAD_LAT);

    // CE gap with counter at 2 holds qualification progress.
    PAD_I = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); chk_in("gap_pre", 1'b0, 1'b0, 1'b0);
    end
    CE = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(); chk_in("gap_ce0", 1'b0, 1'b0, 1'b0);
    end
    CE = 1'b1;
    step(); chk_in("gap_ce1a", 1'b0, 1'b0, 1'b0);
    step(); chk_in("gap_ce1b", 1'b1, 1'b1, 1'b0);
    step(); chk_in("gap_after", 1'b1, 1'b0, 1'b0);
    pad_edge("gfall", 1'b0, PAD_LAT);

    // Reset with counter at 3 restarts qualification.
    PAD_I = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(); chk_in("rq_pre", 1'b0, 1'b0, 1'b0);
    end
    RST = 1'b1;
    step(); chk_in("rq_rst", 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    pad_edge("rq_rise", 1'b1, PAD_LAT);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
